mips_seq_alu: RTL and testbench
===============================

# mips_seq_alu

Parametrised, multi-cycle successor to the single-cycle MIPS ALU. It executes the same 4-bit operation set on WIDTH-bit operands through a start/ready/done handshake. Shift, add/sub, logic and compare ops complete in one cycle. Multiply and divide are iterative (one bit per cycle), so the block sits in the execute stage and stalls the pipeline while busy.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  request; accepted when start_i && ready_o at a rising edge
- alu_op_i  input  4  operation code, sampled at accept
- a_i  input  WIDTH  operand A, sampled at accept
- b_i  input  WIDTH  operand B, sampled at accept
- ready_o  output  1  block idle, can accept
- done_o  output  1  one-cycle pulse: results/flags valid
- result_1  output  WIDTH  primary result (low product / quotient)
- result_2  output  WIDTH  secondary result (high product / remainder), else 0
- over_flow  output  1  signed overflow (add/sub only)
- unsig_over_flow  output  1  carry out (add) / borrow (sub)
- equal  output  1  a == b for the accepted operands
- div_zero  output  1  divide issued with b == 0

## Operation
- Op codes:
  - 0000 SLL: a << b[SHW-1:0].
  - 0001 SRA: arithmetic right shift.
  - 0010 SRL: logical right shift.
  - 0011 MULU: 2·WIDTH unsigned product; result_1 = low half, result_2 = high half.
  - 0100 DIVU: unsigned quotient in result_1, remainder in result_2.
  - 0101 ADD.
  - 0110 SUB.
  - 0111 AND.
  - 1000 OR.
  - 1001 XOR.
  - 1010 NOR.
  - 1011 SLT signed: result_1 = 1 or 0.
  - 1100 SLTU unsigned.
  - 1101–1111: result_1 = result_2 = 0, all flags 0, one-cycle latency.
- result_2 = 0 for every op except MULU/DIVU.
- over_flow:
  - ADD: operands have equal sign and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
- unsig_over_flow:
  - ADD: carry out of bit WIDTH-1.
  - SUB: 1 iff a < b unsigned (borrow).
- over_flow and unsig_over_flow are 0 for all other ops.
- equal is computed for every op; div_zero is 0 except DIVU with b = 0.
- State machine, states IDLE, MUL, DIV:
  - IDLE: ready_o = 1. On accept of MULU → MUL; DIVU with b ≠ 0 → DIV. Any other op, or DIVU with b = 0, completes in place.
  - MUL: shift-add, one multiplier bit per cycle, counter runs WIDTH cycles, then → IDLE with done_o.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then → IDLE with done_o.
- DIVU with b = 0: result_1 = all ones, result_2 = a, div_zero = 1, one-cycle latency.
- Operands and op are latched at accept. Input changes while busy have no effect; start_i while ready_o = 0 is ignored (not queued).
- Results and flags hold their last values until the next completion overwrites them.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, ready_o = 1, done_o = 0.
  - result_1, result_2 = 0; all flags 0; iteration counter = 0.
- Reset asserted mid MUL/DIV aborts the operation. No done_o is issued for it.
- Single-cycle ops: accept at edge N → results/flags registered at edge N; done_o high during cycle N to N+1. ready_o stays 1, so back-to-back accepts every cycle are legal.
- MULU/DIVU: accept at edge N → ready_o low from N until the completion edge N+WIDTH. done_o and ready_o are high after edge N+WIDTH. A new start may be accepted at edge N+WIDTH+1 (i.e. in the done cycle).
- done_o is never high for two consecutive cycles for the same operation. It is high for consecutive cycles only when separate back-to-back ops complete.
- Counter terminal value is WIDTH-1. No wrap beyond it; the counter clears on entering IDLE.

## Test plan
- Reset, then WIDTH=32 ADD a=0x7FFFFFFF, b=1 → after 1 cycle done_o: result_1=0x80000000, over_flow=1, unsig_over_flow=0; ADD 0xFFFFFFFF+1 → result_1=0, unsig_over_flow=1, over_flow=0.
- SUB a=3, b=5 → result_1=0xFFFFFFFE, unsig_over_flow=1, over_flow=0, equal=0. SLT a=0xFFFFFFFF, b=1 → 1; SLTU same operands → 0. SRA 0x80000000 by b=0x24 (uses 4) → 0xF8000000.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF → ready_o low 32 cycles; done_o at edge N+32 with result_1=0x00000001, result_2=0xFFFFFFFE. Operand changes during MUL have no effect; start_i pulses during MUL are ignored.
- DIVU a=100, b=7 → result_1=14, result_2=2 after 32 cycles. DIVU a=9, b=0 → 1 cycle: result_1=0xFFFFFFFF, result_2=9, div_zero=1.
- Assert rst_n low at cycle 10 of a DIVU → all outputs 0, ready_o=1, no done_o. Then a new AND 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0.
- WIDTH=8 instance: MULU 0xFF*0xFF → low 0x01, high 0xFE after 8 cycles. Back-to-back ADD/XOR/NOR accepted on consecutive edges, with done_o high three cycles in a row.

Source files
------------

// File: rtl/mips_seq_alu.sv
// Multi-cycle MIPS ALU: single-cycle shift/arith/logic/compare ops plus
// iterative shift-add multiply and restoring divide behind a start/ready/done handshake.
module mips_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       alu_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_1,
  output logic [WIDTH-1:0] result_2,
  output logic             over_flow,
  output logic             unsig_over_flow,
  output logic             equal,
  output logic             div_zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRA  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0010;
  localparam logic [3:0] OP_MULU = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  typedef enum logic [1:0] {IDLE = 2'b00, MUL = 2'b01, DIV = 2'b10} state_t;

  state_t           state_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] opnd_r;   // multiplicand or divisor
  logic [WIDTH-1:0] hi_r;     // partial product high half / partial remainder
  logic [WIDTH-1:0] lo_r;     // multiplier shifting out / dividend shifting into quotient
  logic             eq_r;

  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] res1_s, res2_s;
  logic             ovf_s, uovf_s, dz_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_trial_s;
  logic [WIDTH-1:0] div_rem_s, div_quo_s;
  logic             qbit_s;

  // Single-cycle datapath results for the operation presented at the inputs
  always_comb begin
    add_s  = {1'b0, a_i} + {1'b0, b_i};
    sub_s  = {1'b0, a_i} - {1'b0, b_i};
    res1_s = {WIDTH{1'b0}};
    res2_s = {WIDTH{1'b0}};
    ovf_s  = 1'b0;
    uovf_s = 1'b0;
    dz_s   = 1'b0;
    case (alu_op_i)
      OP_SLL:  res1_s = a_i << b_i[SHW-1:0];
      OP_SRA:  res1_s = $signed(a_i) >>> b_i[SHW-1:0];
      OP_SRL:  res1_s = a_i >> b_i[SHW-1:0];
      OP_DIVU: begin
        if (b_i == {WIDTH{1'b0}}) begin
          res1_s = {WIDTH{1'b1}};
          res2_s = a_i;
          dz_s   = 1'b1;
        end else begin
          dz_s   = 1'b0;
        end
      end
      OP_ADD: begin
        res1_s = add_s[WIDTH-1:0];
        ovf_s  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_s[WIDTH-1] != a_i[WIDTH-1]);
        uovf_s = add_s[WIDTH];
      end
      OP_SUB: begin
        res1_s = sub_s[WIDTH-1:0];
        ovf_s  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_s[WIDTH-1] != a_i[WIDTH-1]);
        uovf_s = sub_s[WIDTH];
      end
      OP_AND:  res1_s = a_i & b_i;
      OP_OR:   res1_s = a_i | b_i;
      OP_XOR:  res1_s = a_i ^ b_i;
      OP_NOR:  res1_s = ~(a_i | b_i);
      OP_SLT:  res1_s = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: res1_s = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: res1_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration step of the multiplier and of the restoring divider
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opnd_r};
    if (div_trial_s[WIDTH]) begin
      div_rem_s = div_shift_s[WIDTH-1:0];
      qbit_s    = 1'b0;
    end else begin
      div_rem_s = div_trial_s[WIDTH-1:0];
      qbit_s    = 1'b1;
    end
    div_quo_s = {lo_r[WIDTH-2:0], qbit_s};
  end

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      cnt_r           <= {SHW{1'b0}};
      opnd_r          <= {WIDTH{1'b0}};
      hi_r            <= {WIDTH{1'b0}};
      lo_r            <= {WIDTH{1'b0}};
      eq_r            <= 1'b0;
      ready_o         <= 1'b1;
      done_o          <= 1'b0;
      result_1        <= {WIDTH{1'b0}};
      result_2        <= {WIDTH{1'b0}};
      over_flow       <= 1'b0;
      unsig_over_flow <= 1'b0;
      equal           <= 1'b0;
      div_zero        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= {SHW{1'b0}};
          if (start_i) begin
            eq_r <= (a_i == b_i);
            if (alu_op_i == OP_MULU) begin
              state_r <= MUL;
              ready_o <= 1'b0;
              opnd_r  <= a_i;
              hi_r    <= {WIDTH{1'b0}};
              lo_r    <= b_i;
            end else if ((alu_op_i == OP_DIVU) && (b_i != {WIDTH{1'b0}})) begin
              state_r <= DIV;
              ready_o <= 1'b0;
              opnd_r  <= b_i;
              hi_r    <= {WIDTH{1'b0}};
              lo_r    <= a_i;
            end else begin
              result_1        <= res1_s;
              result_2        <= res2_s;
              over_flow       <= ovf_s;
              unsig_over_flow <= uovf_s;
              equal           <= (a_i == b_i);
              div_zero        <= dz_s;
              done_o          <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          if (state_r == MUL) begin
            hi_r <= mul_sum_s[WIDTH:1];
            lo_r <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
          end else begin
            hi_r <= div_rem_s;
            lo_r <= div_quo_s;
          end
          if (cnt_r == CNT_LAST) begin
            result_1        <= (state_r == MUL) ? {mul_sum_s[0], lo_r[WIDTH-1:1]} : div_quo_s;
            result_2        <= (state_r == MUL) ? mul_sum_s[WIDTH:1] : div_rem_s;
            over_flow       <= 1'b0;
            unsig_over_flow <= 1'b0;
            equal           <= eq_r;
            div_zero        <= 1'b0;
            done_o          <= 1'b1;
            ready_o         <= 1'b1;
            state_r         <= IDLE;
            cnt_r           <= {SHW{1'b0}};
          end else begin
            cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
          cnt_r   <= {SHW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_seq_alu.sv
// Directed bench for mips_seq_alu: 32-bit vector table plus multi-cycle,
// reset-abort and 8-bit back-to-back sequences.
module tb_mips_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start32 = 1'b0;
  logic [3:0]  op32 = 4'h0;
  logic [31:0] a32 = 32'h0, b32 = 32'h0;
  logic        rdy32, done32, ovf32, uovf32, eq32, dz32;
  logic [31:0] r1_32, r2_32;

  logic        start8 = 1'b0;
  logic [3:0]  op8 = 4'h0;
  logic [7:0]  a8 = 8'h0, b8 = 8'h0;
  logic        rdy8, done8, ovf8, uovf8, eq8, dz8;
  logic [7:0]  r1_8, r2_8;

  mips_seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(start32), .alu_op_i(op32), .a_i(a32), .b_i(b32),
    .ready_o(rdy32), .done_o(done32), .result_1(r1_32), .result_2(r2_32),
    .over_flow(ovf32), .unsig_over_flow(uovf32), .equal(eq32), .div_zero(dz32));

  mips_seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .alu_op_i(op8), .a_i(a8), .b_i(b8),
    .ready_o(rdy8), .done_o(done8), .result_1(r1_8), .result_2(r2_8),
    .over_flow(ovf8), .unsig_over_flow(uovf8), .equal(eq8), .div_zero(dz8));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r1, r2;
    logic        ovf, uovf, eq, dz;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0;
  endtask

  // Wait for done32 while scrambling inputs and pulsing start; returns cycles since accept
  task automatic wait_done32(output int cyc, output bit ready_seen);
    cyc = 0;
    ready_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!done32) begin
        if (rdy32) ready_seen = 1'b1;
        start32 = cyc[0];
        op32 = 4'h5;
        a32 = $urandom;
        b32 = $urandom;
      end else begin
        start32 = 1'b0;
      end
    end while (!done32 && cyc < 200);
    start32 = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  rs;
    bit  bad;

    vecs[0]  = '{4'h5, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'h5, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'h6, 32'h3, 32'h5, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'hB, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'hC, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'h1, 32'h80000000, 32'h24, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'h0, 32'h1, 32'h21, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'h2, 32'h80000000, 32'h4, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'h7, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'h8, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'h9, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'hA, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'h6, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{4'h6, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'hD, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{4'h4, 32'h9, 32'h0, 32'hFFFFFFFF, 32'h9, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{4'hB, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {r1_32, r2_32}, 64'h0);
    chk("reset ctl", {60'h0, rdy32, done32, ovf32 | uovf32, eq32 | dz32}, {60'h0, 4'b1000});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      issue32(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d done", i), {63'h0, done32}, 64'h1);
      chk($sformatf("vec%0d results", i), {r1_32, r2_32}, {vecs[i].r1, vecs[i].r2});
      chk($sformatf("vec%0d flags", i), {60'h0, ovf32, uovf32, eq32, dz32},
          {60'h0, vecs[i].ovf, vecs[i].uovf, vecs[i].eq, vecs[i].dz});
    end

    // MULU with operand scrambling and stray starts while busy
    issue32(4'h3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul ready low", {63'h0, rdy32}, 64'h0);
    wait_done32(cyc, rs);
    chk("mul latency", cyc, 32);
    chk("mul ready while busy", {63'h0, rs}, 64'h0);
    chk("mul results", {r1_32, r2_32}, {32'h00000001, 32'hFFFFFFFE});
    chk("mul flags", {59'h0, rdy32, ovf32, uovf32, eq32, dz32}, {59'h0, 5'b10010});
    @(posedge clk); #1;
    chk("mul single done", {63'h0, done32}, 64'h0);
    chk("mul hold", {r1_32, r2_32}, {32'h00000001, 32'hFFFFFFFE});

    issue32(4'h4, 32'd100, 32'd7);
    wait_done32(cyc, rs);
    chk("div latency", cyc, 32);
    chk("div results", {r1_32, r2_32}, {32'd14, 32'd2});
    chk("div flags", {60'h0, ovf32, uovf32, eq32, dz32}, 64'h0);

    // Reset during a divide aborts it without a done pulse
    issue32(4'h4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort outputs", {r1_32, r2_32}, 64'h0);
    chk("abort ctl", {60'h0, rdy32, done32, ovf32 | uovf32, eq32 | dz32}, {60'h0, 4'b1000});
    @(negedge clk) rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32 || !rdy32) bad = 1'b1;
    end
    chk("abort no done", {63'h0, bad}, 64'h0);
    issue32(4'h7, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("post-abort and", {31'h0, done32, r1_32}, {31'h0, 1'b1, 32'h00F000F0});

    // 8-bit instance: multiply, then back-to-back single-cycle ops
    start8 = 1'b1; op8 = 4'h3; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done8 && cyc < 50);
    chk("mul8 latency", cyc, 8);
    chk("mul8 results", {48'h0, r1_8, r2_8}, {48'h0, 8'h01, 8'hFE});

    start8 = 1'b1; op8 = 4'h5; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1;
    chk("b2b add", {55'h0, done8, r1_8}, {55'h0, 1'b1, 8'h46});
    op8 = 4'h9; a8 = 8'h0F; b8 = 8'hFF;
    @(posedge clk); #1;
    chk("b2b xor", {55'h0, done8, r1_8}, {55'h0, 1'b1, 8'hF0});
    op8 = 4'hA; a8 = 8'h0F; b8 = 8'hF0;
    @(posedge clk); #1;
    chk("b2b nor", {55'h0, done8, r1_8}, {55'h0, 1'b1, 8'h00});
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("b2b end", {63'h0, done8}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
